timer_counter: RTL and testbench



---
 rtl/timer_counter_pkg.sv | 26 ++
 rtl/tc_prescaler.sv | 24 ++
 rtl/timer_counter.sv | 165 ++++++++++++++++
 tb/tb_timer_counter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer_counter peripheral: register offsets,
// CTRL bit positions and FSM state encoding.
package timer_counter_pkg;

  localparam logic [1:0] TC_CTRL     = 2'd0;
  localparam logic [1:0] TC_PRESET   = 2'd1;
  localparam logic [1:0] TC_COUNT    = 2'd2;
  localparam logic [1:0] TC_PRESCALE = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_IM      = 3;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  // Only MODE=1 auto-reloads; 0, 2 and 3 are one-shot with a held level.
  function automatic logic mode_is_pulse(input logic [1:0] mode);
    return mode == 2'd1;
  endfunction

endpackage

// File: rtl/tc_prescaler.sv
// Divider for the timer: o_tick is high once every i_prescale+1 cycles
// while i_run is set; i_clear restarts the divider from zero.
module tc_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_run,
  input  logic [15:0] i_prescale,
  output logic        o_tick
);

  logic [15:0] r_div;

  assign o_tick = (r_div == i_prescale);

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_div <= '0;
    end else if (i_run) begin
      r_div <= o_tick ? 16'd0 : r_div + 16'd1;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with level (one-shot) or pulse (reload)
// interrupt. Define TC_PRESCALE_EN to add the PRESCALE register at offset 3.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  tc_state_e   r_state;
  tc_state_e   w_next_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_en;
  logic w_tick;
  logic w_last;
  logic w_do_load;
  logic w_do_dec;
  logic w_do_expire;
  logic w_int_clr_en;
  logic w_int_clr_flag;
  logic w_unused_addr;

  assign w_wr_ctrl     = WE && (Addr[3:2] == TC_CTRL);
  assign w_wr_preset   = WE && (Addr[3:2] == TC_PRESET);
  assign w_last        = (r_count <= 32'd1);
  assign w_unused_addr = &{1'b0, Addr[31:4], Addr[1:0]};

  // A CTRL write in the same cycle steers the FSM, so EN=1 enters LOAD and
  // EN=0 leaves CNT on the very edge that performs the write.
  assign w_en = w_wr_ctrl ? Din[CTRL_EN] : r_ctrl[CTRL_EN];

`ifdef TC_PRESCALE_EN
  logic [15:0] r_prescale;
  logic        w_wr_prescale;

  assign w_wr_prescale = WE && (Addr[3:2] == TC_PRESCALE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescale <= '0;
    end else if (w_wr_prescale) begin
      r_prescale <= Din[15:0];
    end
  end

  tc_prescaler u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_do_load || w_wr_prescale),
    .i_run      (r_state == TC_CNT),
    .i_prescale (r_prescale),
    .o_tick     (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= TC_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      TC_IDLE: if (w_en) w_next_state = TC_LOAD;
      TC_LOAD: w_next_state = TC_CNT;
      TC_CNT: begin
        if (!w_en) begin
          w_next_state = TC_IDLE;
        end else if (w_tick && w_last) begin
          w_next_state = TC_INT;
        end
      end
      TC_INT:  w_next_state = TC_IDLE;
      default: w_next_state = TC_IDLE;
    endcase
  end

  always_comb begin
    w_do_load      = 1'b0;
    w_do_dec       = 1'b0;
    w_do_expire    = 1'b0;
    w_int_clr_en   = 1'b0;
    w_int_clr_flag = 1'b0;
    case (r_state)
      TC_LOAD: w_do_load = 1'b1;
      TC_CNT: begin
        w_do_dec    = w_en && w_tick && !w_last;
        w_do_expire = w_en && w_tick && w_last;
      end
      TC_INT: begin
        w_int_clr_flag = mode_is_pulse(r_ctrl[CTRL_MODE_LO +: 2]);
        w_int_clr_en   = !mode_is_pulse(r_ctrl[CTRL_MODE_LO +: 2]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_preset   <= PRESET_RST;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= Din[3:0];
      end else if (w_int_clr_en) begin
        r_ctrl[CTRL_EN] <= 1'b0;
      end

      if (w_wr_preset) begin
        r_preset <= Din;
      end

      if (w_do_load) begin
        r_count <= r_preset;
      end else if (w_do_dec) begin
        r_count <= r_count - 32'd1;
      end else if (w_do_expire) begin
        r_count <= '0;
      end

      // Any CTRL/PRESET write acknowledges a pending level interrupt.
      if (w_do_expire) begin
        r_irq_flag <= 1'b1;
      end else if (w_wr_ctrl || w_wr_preset || w_int_clr_flag) begin
        r_irq_flag <= 1'b0;
      end
    end
  end

  assign IRQ = r_ctrl[CTRL_IM] & r_irq_flag;

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      TC_CTRL:     Dout = {28'b0, r_ctrl};
      TC_PRESET:   Dout = r_preset;
      TC_COUNT:    Dout = r_count;
`ifdef TC_PRESCALE_EN
      TC_PRESCALE: Dout = {16'b0, r_prescale};
`endif
      default:     Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register map, one-shot and reload modes,
// EN-clear hold, IM masking, simultaneous writes, mid-count reset.
module tb_timer_counter;

  localparam logic [31:0] P_RST = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] Addr;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  timer_counter #(.PRESET_RST(P_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  // All driving and sampling happens at the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    step(1);
    WE   = 1'b0;
    Din  = '0;
  endtask

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: observed %h with empty expected queue", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] d;
    expect_v(e);
    Addr = a;
    #1;
    d = Dout;
    check(tag, d);
  endtask

  task automatic chk_irq(input string tag, input logic e);
    expect_v({31'b0, e});
    check(tag, {31'b0, IRQ});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    WE    = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  logic [31:0] ps_exp [7] = '{32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd1, 32'd0};

  initial begin
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;
    @(negedge clk);
    do_reset();

    chk_reg("rst_ctrl",   32'h0, 32'h0);
    chk_reg("rst_preset", 32'h4, P_RST);
    chk_reg("rst_count",  32'h8, 32'h0);
    chk_reg("rst_resv",   32'hC, 32'h0);
    chk_irq("rst_irq", 1'b0);
`ifndef TC_PRESCALE_EN
    wr(32'hC, 32'h1234);
    chk_reg("resv_wr_ignored", 32'hC, 32'h0);
`endif
    wr(32'h8, 32'hFFFF);
    chk_reg("count_ro_idle", 32'h8, 32'h0);

    // One-shot, IM=1: COUNT=3 after E1, INT after E4, EN cleared after E5.
    wr(32'h4, 32'd3);
    chk_reg("preset_rw", 32'h4, 32'd3);
    wr(32'h0, 32'h9);
    chk_irq("m0_e0_irq", 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk_reg("m0_count", 32'h8, 32'd3 - k);
      chk_irq("m0_irq", k == 3);
    end
    step(1);
    chk_reg("m0_en_cleared", 32'h0, 32'h8);
    chk_irq("m0_level_hold", 1'b1);
    step(3);
    chk_irq("m0_level_late", 1'b1);
    wr(32'h0, 32'h0);
    chk_irq("m0_ctrl_wr_clears", 1'b0);

    // Reload mode: one-cycle pulse every 5 cycles, first in INT after E3.
    do_reset();
    wr(32'h4, 32'd2);
    wr(32'h0, 32'hB);
    for (int k = 1; k <= 13; k++) begin
      step(1);
      chk_irq("m1_pulse", (k % 5) == 3);
    end
    chk_reg("m1_en_kept", 32'h0, 32'hB);

    // EN=0 write while counting holds COUNT.
    do_reset();
    wr(32'h4, 32'd8);
    wr(32'h0, 32'h1);
    step(4);
    chk_reg("hold_pre", 32'h8, 32'd5);
    wr(32'h0, 32'h0);
    chk_reg("hold_at_stop", 32'h8, 32'd5);
    step(2);
    chk_reg("hold_idle", 32'h8, 32'd5);
    wr(32'h8, 32'hFFFF);
    chk_reg("hold_count_ro", 32'h8, 32'd5);

    // IM=0 masks; enabling IM through a CTRL write also clears the flag.
    do_reset();
    wr(32'h4, 32'd1);
    wr(32'h0, 32'h1);
    step(2);
    chk_reg("im0_count_zero", 32'h8, 32'd0);
    chk_irq("im0_masked", 1'b0);
    step(1);
    chk_reg("im0_en_cleared", 32'h0, 32'h0);
    wr(32'h0, 32'h8);
    chk_irq("im0_set_im", 1'b0);
    step(2);
    chk_irq("im0_set_im_late", 1'b0);

    // PRESET=0 behaves like PRESET=1.
    do_reset();
    wr(32'h4, 32'd0);
    wr(32'h0, 32'h9);
    step(1);
    chk_reg("p0_loaded", 32'h8, 32'd0);
    chk_irq("p0_cnt_irq", 1'b0);
    step(1);
    chk_irq("p0_int_irq", 1'b1);

    // CTRL write in INT wins over the EN clear; timer restarts.
    do_reset();
    wr(32'h4, 32'd1);
    wr(32'h0, 32'h9);
    step(2);
    chk_irq("ww_int", 1'b1);
    wr(32'h0, 32'h9);
    chk_reg("ww_ctrl_kept", 32'h0, 32'h9);
    chk_irq("ww_flag_cleared", 1'b0);
    step(3);
    chk_irq("ww_reint", 1'b1);

    // PRESET write while running only affects the next LOAD.
    do_reset();
    wr(32'h4, 32'd4);
    wr(32'h0, 32'h1);
    step(1);
    chk_reg("pw_loaded", 32'h8, 32'd4);
    wr(32'h4, 32'd100);
    chk_reg("pw_running", 32'h8, 32'd3);
    step(1);
    chk_reg("pw_running2", 32'h8, 32'd2);
    step(3);
    chk_reg("pw_oneshot_done", 32'h0, 32'h0);
    wr(32'h0, 32'h1);
    step(1);
    chk_reg("pw_new_load", 32'h8, 32'd100);

    // Reset asserted mid-count.
    do_reset();
    wr(32'h4, 32'd50);
    wr(32'h0, 32'h9);
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_reg("mr_count",  32'h8, 32'h0);
    chk_reg("mr_ctrl",   32'h0, 32'h0);
    chk_reg("mr_preset", 32'h4, P_RST);
    chk_irq("mr_irq", 1'b0);
    step(2);
    chk_reg("mr_stays_idle", 32'h8, 32'h0);

`ifdef TC_PRESCALE_EN
    // PRESCALE=2: one decrement every 3 counting cycles.
    do_reset();
    wr(32'hC, 32'd2);
    chk_reg("ps_readback", 32'hC, 32'd2);
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h9);
    for (int k = 0; k < 7; k++) begin
      step(1);
      chk_reg("ps_count", 32'h8, ps_exp[k]);
      chk_irq("ps_irq", k == 6);
    end
`endif

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: observed %0d leftover entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
